// File: rtl/iterative_divider_if.sv
// Request/response bundle between execute-stage control and the divider.
interface iterative_divider_if #(
  parameter int unsigned XLEN = 32
);
  logic            Start;
  logic [1:0]      DivOp;
  logic [XLEN-1:0] Dividend;
  logic [XLEN-1:0] Divisor;
  logic            Busy;
  logic            Done;
  logic [XLEN-1:0] Result;

  // Issuing side: execute-stage control
  modport master (
    output Start, DivOp, Dividend, Divisor,
    input  Busy, Done, Result
  );

  // Divider side
  modport slave (
    input  Start, DivOp, Dividend, Divisor,
    output Busy, Done, Result
  );
endinterface

// File: rtl/iterative_divider.sv
// Radix-2 restoring divide/remainder unit for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the loop.
module iterative_divider #(
  parameter int unsigned XLEN = 32
) (
  input logic                clk,
  input logic                rst,
  iterative_divider_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            sel_rem_q, sel_rem_d;   // 1: REM/REMU, 0: DIV/DIVU
  logic            sign_a_q, sign_a_d;     // dividend negative (signed ops only)
  logic            sign_b_q, sign_b_d;     // divisor negative (signed ops only)
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            signed_op;
  logic            div_zero;
  logic            sgn_ovf;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  // Shifted partial remainder and trial subtraction; trial[XLEN] set means negative
  assign rem_sh = {rem_q, quo_q[XLEN-1]};
  assign trial  = rem_sh - {1'b0, dvsr_q};

  // Sign correction applied to the unsigned magnitudes after the loop
  assign quo_fix = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
  assign rem_fix = sign_a_q ? -rem_q : rem_q;

  // Request decode for the accept edge
  assign signed_op = ~bus.DivOp[0];
  assign div_zero  = (bus.Divisor == '0);
  assign sgn_ovf   = signed_op
                     && (bus.Dividend == {1'b1, {(XLEN-1){1'b0}}})
                     && (bus.Divisor == '1);

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sel_rem_q <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      dvsr_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_rem_q <= sel_rem_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      dvsr_q    <= dvsr_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_rem_d = sel_rem_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    dvsr_d    = dvsr_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    result_d  = result_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.Start) begin
          sel_rem_d = bus.DivOp[1];
          sign_a_d  = signed_op & bus.Dividend[XLEN-1];
          sign_b_d  = signed_op & bus.Divisor[XLEN-1];
          // abs() of the most negative value wraps to itself, read as unsigned
          quo_d     = sign_a_d ? -bus.Dividend : bus.Dividend;
          dvsr_d    = sign_b_d ? -bus.Divisor : bus.Divisor;
          rem_d     = '0;
          cnt_d     = CNT_W'(XLEN);
          if (div_zero) begin
            result_d = bus.DivOp[1] ? bus.Dividend : '1;
            state_d  = S_DONE;
          end else if (sgn_ovf) begin
            result_d = bus.DivOp[1] ? '0 : bus.Dividend;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (trial[XLEN]) begin
          rem_d = rem_sh[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end else begin
          rem_d = trial[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIXUP;
        end
      end

      S_FIXUP: begin
        result_d = sel_rem_q ? rem_fix : quo_fix;
        state_d  = S_DONE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status flags are registered copies of the next state
  always_comb begin
    busy_d = (state_d == S_CALC) || (state_d == S_FIXUP);
    done_d = (state_d == S_DONE);
  end

  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;
  assign bus.Result = result_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider against an arithmetic reference model.
module tb_iterative_divider;

  localparam int unsigned XLEN = 32;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  iterative_divider_if #(.XLEN(XLEN)) bus ();

  iterative_divider #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result from RISC-V M-extension rules
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] r;
    if (b == 32'd0) begin
      r = op[1] ? a : 32'hFFFF_FFFF;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = op[1] ? 32'd0 : 32'h8000_0000;
    end else begin
      case (op)
        2'b00:   r = 32'($signed(a) / $signed(b));
        2'b01:   r = a / b;
        2'b10:   r = 32'($signed(a) % $signed(b));
        default: r = a % b;
      endcase
    end
    return r;
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Wait for Done after an accept edge; lat=0 when it never comes
  task automatic wait_done(output int lat, output logic [31:0] res);
    bit found;
    found = 1'b0;
    lat   = 0;
    res   = 'x;
    for (int k = 1; k <= 100 && !found; k++) begin
      @(negedge clk);
      if (bus.Done === 1'b1) begin
        found = 1'b1;
        lat   = k;
        res   = bus.Result;
      end
    end
  endtask

  // Issue one operation with a single-cycle Start pulse
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res);
    @(negedge clk);
    bus.Start    = 1'b1;
    bus.DivOp    = op;
    bus.Dividend = a;
    bus.Divisor  = b;
    @(posedge clk);
    #1;
    bus.Start    = 1'b0;
    wait_done(lat, res);
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.Start    = 1'b0;
    bus.DivOp    = 2'b00;
    bus.Dividend = '0;
    bus.Divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Result !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b result=%h, want 0 0 00000000",
               bus.Busy, bus.Done, bus.Result);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.Done !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_done: done=%b, want 0", bus.Done);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  ops [14];
    logic [31:0] as  [14];
    logic [31:0] bs  [14];
    int          lat;
    logic [31:0] res;
    ops = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10,
            2'b01, 2'b11, 2'b10, 2'b00};
    as  = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h7, 32'h1234_5678,
            32'h1234_5678, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
            32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
    bs  = '{32'd7, 32'd7, 32'h2, 32'h2, 32'hFFFF_FFFE, 32'h0, 32'h0, 32'h0,
            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h3, 32'h1};
    for (int i = 0; i < 14; i++) begin
      run_op(ops[i], as[i], bs[i], lat, res);
      checks++;
      if (lat !== ref_latency(ops[i], as[i], bs[i]) || res !== ref_result(ops[i], as[i], bs[i])) begin
        failures++;
        $display("FAIL directed_%0d op=%b a=%h b=%h: latency=%0d result=%h, want latency=%0d result=%h",
                 i, ops[i], as[i], bs[i], lat, res,
                 ref_latency(ops[i], as[i], bs[i]), ref_result(ops[i], as[i], bs[i]));
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] res;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = -32'($urandom_range(1, 15));
        3: a = 32'h8000_0000;
        default: ;
      endcase
      run_op(op, a, b, lat, res);
      checks++;
      if (lat !== ref_latency(op, a, b) || res !== ref_result(op, a, b)) begin
        failures++;
        $display("FAIL random_%0d op=%b a=%h b=%h: latency=%0d result=%h, want latency=%0d result=%h",
                 i, op, a, b, lat, res, ref_latency(op, a, b), ref_result(op, a, b));
      end
    end
  endtask

  task automatic test_busy_ignore_hold();
    int          busy_bad;
    int          done_at;
    logic [31:0] held;
    busy_bad = 0;
    done_at  = 0;
    held     = 'x;
    @(negedge clk);
    bus.Start    = 1'b1;
    bus.DivOp    = 2'b01;
    bus.Dividend = 32'd1000;
    bus.Divisor  = 32'd10;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    for (int k = 1; k <= 40 && done_at == 0; k++) begin
      @(negedge clk);
      if (k == 5) begin
        bus.Start    = 1'b1;
        bus.DivOp    = 2'b11;
        bus.Dividend = 32'd55;
        bus.Divisor  = 32'd4;
      end
      if (k == 8) bus.Start = 1'b0;
      if (k <= 33 && (bus.Busy !== 1'b1 || bus.Done !== 1'b0)) busy_bad++;
      if (bus.Done === 1'b1) begin
        done_at = k;
        held    = bus.Result;
        if (bus.Busy !== 1'b0) busy_bad++;
      end
    end
    checks++;
    if (busy_bad != 0) begin
      failures++;
      $display("FAIL busy_window: %0d bad busy/done samples, want 0", busy_bad);
    end
    checks++;
    if (done_at != 34 || held !== 32'd100) begin
      failures++;
      $display("FAIL ignored_start: done_cycle=%0d result=%h, want 34 00000064", done_at, held);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (bus.Result !== 32'd100 || bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
      failures++;
      $display("FAIL result_hold: result=%h done=%b busy=%b, want 00000064 0 0",
               bus.Result, bus.Done, bus.Busy);
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    stray = 0;
    @(negedge clk);
    bus.Start    = 1'b1;
    bus.DivOp    = 2'b01;
    bus.Dividend = 32'd999;
    bus.Divisor  = 32'd3;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Result !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_calc: busy=%b done=%b result=%h, want 0 0 00000000",
               bus.Busy, bus.Done, bus.Result);
    end
    rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL no_done_after_reset: %0d stray busy/done samples, want 0", stray);
    end
  endtask

  task automatic test_back_to_back();
    int          lat;
    logic [31:0] res;
    run_op(2'b01, 32'hFFFF_FFFF, 32'h1, lat, res);
    checks++;
    if (lat != 34 || res !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL b2b_first: latency=%0d result=%h, want 34 ffffffff", lat, res);
    end
    // Still inside the DONE cycle: this Start is accepted on the next edge
    bus.Start    = 1'b1;
    bus.DivOp    = 2'b11;
    bus.Dividend = 32'hFFFF_FFFF;
    bus.Divisor  = 32'h10;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    wait_done(lat, res);
    checks++;
    if (lat != 34 || res !== 32'h0000_000F) begin
      failures++;
      $display("FAIL b2b_second: latency=%0d result=%h, want 34 0000000f", lat, res);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_busy_ignore_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
